// File: rtl/cache_controller_if.sv
// Processor/set/memory-side signal bundle for cache_controller.
// slave is the controller's view; master is the surrounding logic's view.
`ifndef CACHE_T
`define CACHE_T 26
`endif
`ifndef CACHE_S
`define CACHE_S 2
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

interface cache_controller_if #(
   parameter int TAG_WIDTH = `CACHE_T
);
   logic                 req_i;
   logic                 write_i;
   logic [31:0]          addr_i;
   logic                 hit_i;
   logic                 dirty_i;
   logic [TAG_WIDTH-1:0] tag_i;
   logic                 mem_ready_i;
   logic [4:0]           control_o;
   logic                 mem_read_o;
   logic                 mem_write_o;
   logic [31:0]          mem_addr_o;
   logic                 ready_o;

   modport slave (
      input  req_i, write_i, addr_i, hit_i, dirty_i, tag_i, mem_ready_i,
      output control_o, mem_read_o, mem_write_o, mem_addr_o, ready_o
   );

   modport master (
      output req_i, write_i, addr_i, hit_i, dirty_i, tag_i, mem_ready_i,
      input  control_o, mem_read_o, mem_write_o, mem_addr_o, ready_o
   );
endinterface

// File: rtl/cache_controller.sv
// Access sequencer for one cache path: serves hits, and on a miss runs a
// word-by-word write-back of a dirty victim followed by a line refill.
`ifndef CACHE_T
`define CACHE_T 26
`endif
`ifndef CACHE_S
`define CACHE_S 2
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_controller #(
   parameter int TAG_WIDTH    = `CACHE_T,
   parameter int SET_WIDTH    = `CACHE_S,
   parameter int OFFSET_WIDTH = `CACHE_B
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   cache_controller_if.slave      bus
);
   localparam int CNT_WIDTH = OFFSET_WIDTH - 2;

   // {write_en, set_valid, set_dirty, strategy_en, offset_sel}
   localparam logic [4:0] CTRL_READ_HIT  = 5'b00011;
   localparam logic [4:0] CTRL_WRITE_HIT = 5'b11111;
   localparam logic [4:0] CTRL_REFILL    = 5'b11000;

   typedef enum logic [1:0] {IDLE, WRITE_BACK, REFILL} state_t;

   state_t               state_reg, state_next;
   logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
   logic [4:0]           control;
   logic                 mem_read, mem_write, ready;
   logic [31:0]          mem_addr;
   logic                 last_word;
   logic [SET_WIDTH-1:0] index;

   assign last_word = &cnt_reg;
   assign index     = bus.addr_i[OFFSET_WIDTH+SET_WIDTH-1:OFFSET_WIDTH];

   // Byte-offset bits only matter to the set's word select, not here.
   logic unused_offset;
   assign unused_offset = &{1'b0, bus.addr_i[OFFSET_WIDTH-1:0]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      control    = 5'b00000;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = 32'h0;
      ready      = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (bus.req_i) begin
               if (bus.hit_i) begin
                  ready   = 1'b1;
                  control = bus.write_i ? CTRL_WRITE_HIT : CTRL_READ_HIT;
               end else begin
                  cnt_next   = '0;
                  state_next = bus.dirty_i ? WRITE_BACK : REFILL;
               end
            end
         end
         WRITE_BACK: begin
            // Victim address comes from the stored tag, not the request.
            mem_write = 1'b1;
            mem_addr  = {bus.tag_i, index, cnt_reg, 2'b00};
            if (bus.mem_ready_i) begin
               if (last_word) begin
                  cnt_next   = '0;
                  state_next = REFILL;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         REFILL: begin
            mem_read = 1'b1;
            mem_addr = {bus.addr_i[31:OFFSET_WIDTH], cnt_reg, 2'b00};
            if (bus.mem_ready_i) begin
               control = CTRL_REFILL;
               if (last_word) begin
                  cnt_next   = '0;
                  state_next = IDLE;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign bus.control_o   = control;
   assign bus.mem_read_o  = mem_read;
   assign bus.mem_write_o = mem_write;
   assign bus.mem_addr_o  = mem_addr;
   assign bus.ready_o     = ready;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with W=4 words per line, 4 sets.
module tb_cache_controller;
   localparam int TW = 26;
   localparam int SW = 2;
   localparam int OW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_controller_if #(.TAG_WIDTH(TW)) bus ();

   cache_controller #(
      .TAG_WIDTH(TW), .SET_WIDTH(SW), .OFFSET_WIDTH(OW)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [4:0] ctrl, input logic rd,
                             input logic wr, input logic [31:0] a, input logic rdy);
      check({tag, ".control"},   32'(bus.control_o),   32'(ctrl));
      check({tag, ".mem_read"},  32'(bus.mem_read_o),  32'(rd));
      check({tag, ".mem_write"}, 32'(bus.mem_write_o), 32'(wr));
      check({tag, ".mem_addr"},  bus.mem_addr_o,       a);
      check({tag, ".ready"},     32'(bus.ready_o),     32'(rdy));
   endtask

   // Inputs change 1ns after the edge; outputs are checked 1ns later.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   logic [31:0] wb_exp [4];

   initial begin
      wb_exp = '{32'h0000_48F0, 32'h0000_48F4, 32'h0000_48F8, 32'h0000_48FC};
      rst             = 1'b1;
      bus.req_i       = 1'b0;
      bus.write_i     = 1'b0;
      bus.addr_i      = 32'h0;
      bus.hit_i       = 1'b0;
      bus.dirty_i     = 1'b0;
      bus.tag_i       = '0;
      bus.mem_ready_i = 1'b0;
      repeat (2) tick();

      rst = 1'b0;
      bus.mem_ready_i = 1'b1;
      settle();
      check_outs("reset_idle", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0);
      $display("reset: idle outputs checked");

      tick();
      bus.req_i = 1'b1; bus.write_i = 1'b0; bus.hit_i = 1'b1; bus.addr_i = 32'h0000_0020;
      settle();
      check_outs("read_hit", 5'b00011, 1'b0, 1'b0, 32'h0, 1'b1);
      $display("read hit addr=%h", bus.addr_i);

      tick();
      bus.write_i = 1'b1; bus.addr_i = 32'h0000_1234;
      settle();
      check_outs("write_hit", 5'b11111, 1'b0, 1'b0, 32'h0, 1'b1);
      $display("write hit addr=%h", bus.addr_i);

      tick();
      bus.write_i = 1'b0;
      settle();
      check_outs("b2b_read_hit", 5'b00011, 1'b0, 1'b0, 32'h0, 1'b1);
      $display("back-to-back read hit addr=%h", bus.addr_i);

      tick();
      bus.req_i = 1'b0; bus.hit_i = 1'b0;
      settle();

      // Clean miss, memory always ready.
      tick();
      bus.req_i = 1'b1; bus.write_i = 1'b0; bus.addr_i = 32'hABCD_0010;
      bus.hit_i = 1'b0; bus.dirty_i = 1'b0; bus.mem_ready_i = 1'b1;
      settle();
      check_outs("clean_miss.c0", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         settle();
         check_outs($sformatf("clean_refill%0d", k), 5'b11000, 1'b1, 1'b0,
                    32'hABCD_0010 + 32'(4 * k), 1'b0);
      end
      tick();
      bus.hit_i = 1'b1;
      settle();
      check_outs("clean_miss.serve", 5'b00011, 1'b0, 1'b0, 32'h0, 1'b1);
      $display("clean miss read addr=%h served at cycle 5", bus.addr_i);
      tick();
      bus.req_i = 1'b0; bus.hit_i = 1'b0;
      settle();

      // Dirty write miss, memory stalls every other cycle.
      tick();
      bus.req_i = 1'b1; bus.write_i = 1'b1; bus.addr_i = 32'h1234_5678;
      bus.hit_i = 1'b0; bus.dirty_i = 1'b1; bus.tag_i = 26'h000_0123; bus.mem_ready_i = 1'b0;
      settle();
      check_outs("dirty_miss.c0", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         bus.mem_ready_i = 1'b0;
         settle();
         check_outs($sformatf("wb_stall%0d", k), 5'b00000, 1'b0, 1'b1, wb_exp[k], 1'b0);
         tick();
         bus.mem_ready_i = 1'b1;
         settle();
         check_outs($sformatf("wb_word%0d", k), 5'b00000, 1'b0, 1'b1, wb_exp[k], 1'b0);
      end
      bus.dirty_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         bus.mem_ready_i = 1'b0;
         settle();
         check_outs($sformatf("rf_stall%0d", k), 5'b00000, 1'b1, 1'b0,
                    32'h1234_5670 + 32'(4 * k), 1'b0);
         tick();
         bus.mem_ready_i = 1'b1;
         settle();
         check_outs($sformatf("rf_word%0d", k), 5'b11000, 1'b1, 1'b0,
                    32'h1234_5670 + 32'(4 * k), 1'b0);
      end
      tick();
      bus.hit_i = 1'b1;
      settle();
      check_outs("dirty_miss.serve", 5'b11111, 1'b0, 1'b0, 32'h0, 1'b1);
      $display("dirty miss write addr=%h served at cycle 17", bus.addr_i);
      tick();
      bus.req_i = 1'b0; bus.hit_i = 1'b0; bus.write_i = 1'b0;
      settle();

      // Reset in the middle of a refill.
      tick();
      bus.req_i = 1'b1; bus.addr_i = 32'h0000_0040; bus.hit_i = 1'b0;
      bus.dirty_i = 1'b0; bus.mem_ready_i = 1'b1;
      settle();
      check_outs("rst_miss.c0", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         tick();
         settle();
         check_outs($sformatf("rst_refill%0d", k), 5'b11000, 1'b1, 1'b0,
                    32'h0000_0040 + 32'(4 * k), 1'b0);
      end
      tick();
      rst = 1'b1;
      settle();
      check_outs("rst_refill2", 5'b11000, 1'b1, 1'b0, 32'h0000_0048, 1'b0);
      tick();
      rst = 1'b0; bus.req_i = 1'b0;
      settle();
      check_outs("after_reset", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0);
      $display("reset during refill: returned to idle");

      tick();
      bus.req_i = 1'b1;
      settle();
      check_outs("restart.c0", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         tick();
         settle();
         check_outs($sformatf("restart_word%0d", k), 5'b11000, 1'b1, 1'b0,
                    32'h0000_0040 + 32'(4 * k), 1'b0);
      end
      $display("restarted refill addr=%h from word 0", bus.addr_i);
      tick();
      bus.req_i = 1'b0;
      settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing FSM for one cache access path: takes processor read/write requests, drives the 5-bit control bus of the addressed cache set, and runs the memory-side word-by-word write-back and refill on a miss. It sits between the processor/stall logic and the set array. Its memory address output feeds the set's `mem_addr_i` and the memory port. The set's read data goes to memory directly and does not pass through this block.

## Interface
- `TAG_WIDTH`, default `` `CACHE_T ``: tag bits.
- `SET_WIDTH`, default `` `CACHE_S ``: set-index bits. `TAG_WIDTH + SET_WIDTH + OFFSET_WIDTH` must equal 32.
- `OFFSET_WIDTH`, default `` `CACHE_B ``: byte-offset bits. Must be at least 3. W = 2^(OFFSET_WIDTH-2) words per line.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in 1: processor request. It must hold `write_i`, `addr_i` and write data stable until `ready_o`.
- `write_i` in 1: 1 = write, 0 = read.
- `addr_i` in 32: processor byte address.
- `hit_i` in 1: hit from the set.
- `dirty_i` in 1: dirty bit of the selected line.
- `tag_i` in TAG_WIDTH: tag of the selected (victim) line.
- `mem_ready_i` in 1: memory accepts or returns one word this cycle.
- `control_o` out 5: fields are {write_en, set_valid, set_dirty, strategy_en, offset_sel}.
- `mem_read_o` out 1: refill read request.
- `mem_write_o` out 1: write-back request.
- `mem_addr_o` out 32: word address for the memory transfer and the set's `mem_addr_i`.
- `ready_o` out 1: the request completes this cycle. Read data is valid this cycle, and a write commits at this cycle's edge.

## Operation
- State is {IDLE, WRITE_BACK, REFILL}. A word counter `cnt` is OFFSET_WIDTH-2 bits wide.
- In IDLE with `req_i`=0, all outputs are 0.
- **IDLE, `req_i`=1, `hit_i`=1** (serve):
  - `ready_o`=1.
  - Read: `control_o` = 5'b00011.
  - Write: `control_o` = 5'b11111. The processor word is written and the line is marked dirty.
  - The state stays IDLE. `strategy_en` is asserted only on serve cycles, so replacement state updates exactly once per access.
- **IDLE, `req_i`=1, `hit_i`=0**:
  - `control_o` = 0 and `ready_o` = 0.
  - `cnt` is cleared.
  - Next state is WRITE_BACK if `dirty_i`=1, otherwise REFILL.
- **WRITE_BACK**:
  - `mem_write_o`=1.
  - `mem_addr_o` = {`tag_i`, `addr_i` index, `cnt`, 2'b00}.
  - `control_o` = 5'b00000, so the set reads at the `mem_addr_i` offset from the victim line.
  - On `mem_ready_i`: `cnt`++. On the word where `cnt`=W-1, clear `cnt` and go to REFILL.
  - `tag_i` is stable because nothing is written during WRITE_BACK.
- **REFILL**:
  - `mem_read_o`=1.
  - `mem_addr_o` = {`addr_i` tag, index, `cnt`, 2'b00}.
  - When `mem_ready_i`=1: `control_o` = 5'b11000. The word is written into the victim line, the line's tag is set from `addr_i` and valid=1, and dirty is cleared. `cnt`++.
  - When `mem_ready_i`=0: `control_o` = 0.
  - After word W-1 is accepted, go to IDLE. The pending request then hits and is served through the normal hit path.
- `mem_ready_i` is ignored in IDLE.
- `mem_read_o` and `mem_write_o` are never both 1.
- `mem_addr_o` = 0 in IDLE.
- `cnt` wraps only through the explicit clear. It never exceeds W-1.

## Timing
- Reset: state IDLE, `cnt`=0. `control_o`, `mem_read_o`, `mem_write_o`, `mem_addr_o` and `ready_o` all read 0 in the cycle after reset while `req_i`=0.
- Reset mid-WRITE_BACK or mid-REFILL:
  - The block returns to IDLE at the next edge and drops the memory strobes.
  - The shared `rst_i` also invalidates every line, so a partial refill is never visible.
- Outputs are combinational from state, `cnt` and inputs. `ready_o` follows `req_i`/`hit_i` in the same cycle.
- Latency is counted from the request cycle (cycle 0) with `mem_ready_i` held at 1:
  - Hit: `ready_o` in cycle 0.
  - Clean miss: `ready_o` in cycle W+1.
  - Dirty miss: `ready_o` in cycle 2W+1.
- Each cycle with `mem_ready_i`=0 in WRITE_BACK or REFILL adds one cycle of latency.
- Back-to-back hits complete one per cycle.

## Test plan
Scenarios use OFFSET_WIDTH=4 (W=4) and SET_WIDTH=2.
- **Read hit:** `req_i`=1, `write_i`=0, `hit_i`=1 → `ready_o`=1 and `control_o`=5'b00011 in the same cycle. No memory strobes.
- **Write hit:** `write_i`=1, `hit_i`=1, `addr_i`=32'h0000_1234 → `control_o`=5'b11111, `ready_o`=1. Two consecutive hit requests → two `ready_o` pulses in two consecutive cycles.
- **Clean miss:** `addr_i`=32'hABCD_0010, `hit_i`=0, `dirty_i`=0, `mem_ready_i`=1 →
  - Cycles 1-4: `mem_read_o`=1, `mem_addr_o` = 32'hABCD_0010, …14, …18, …1C, `control_o`=5'b11000.
  - Cycle 5: `ready_o`=1 (model the set hitting from cycle 5).
- **Dirty miss with memory stalls:** `tag_i` = victim tag, `mem_ready_i` low every other cycle →
  - Four `mem_write_o` words with addresses {`tag_i`, index, 0..3, 00}, then four refill words.
  - No set write on stalled cycles.
  - `ready_o` at cycle 2W+1 plus the number of stall cycles.
- **Reset in REFILL:** assert `rst_i` after 2 refill words → all outputs 0 the next cycle and state IDLE. A new request afterwards restarts from `cnt`=0.
